// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the unified memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        CORE  = 2'b01,
        DEBUG = 2'b10
    } owner_t;

    // Matches the core's memwrite encoding
    localparam logic [1:0] MW_READ  = 2'b00;
    localparam logic [1:0] MW_WORD  = 2'b01;
    localparam logic [1:0] MW_BYTE  = 2'b10;
    localparam logic [1:0] MW_DWORD = 2'b11;

    localparam logic [7:0] BE_ALL = 8'hFF;

endpackage

// File: rtl/mem_lane_gen.sv
// Size code + low address bits -> byte enables, lane-replicated store data, misalign flag.
module mem_lane_gen
    import mem_arb_pkg::*;
(
    input  logic [1:0]  i_we,
    input  logic [2:0]  i_addr,
    input  logic [63:0] i_wdata,
    output logic [7:0]  o_be,
    output logic [63:0] o_wdata,
    output logic        o_misalign
);

    always_comb begin
        o_be       = BE_ALL;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        case (i_we)
            MW_WORD: begin
                o_be       = i_addr[2] ? 8'hF0 : 8'h0F;
                o_wdata    = {2{i_wdata[31:0]}};
                o_misalign = (i_addr[1:0] != 2'b00);
            end
            MW_BYTE: begin
                o_be    = 8'h01 << i_addr;
                o_wdata = {8{i_wdata[7:0]}};
            end
            MW_DWORD: begin
                o_misalign = (i_addr != 3'b000);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and a debug/DMA requester;
// each access runs issue -> wait for m_ready (or timeout) -> one-cycle response.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          c_req,
    input  logic [1:0]    c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ack,
    output logic          c_err,
    input  logic          d_req,
    input  logic [1:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          d_err,
    output logic          m_en,
    output logic          m_we,
    output logic [7:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          stall,
    output logic [1:0]    owner
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    owner_t          r_owner;
    owner_t          r_last_owner;
    owner_t          w_grant;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic [DW-1:0]   r_c_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            w_any_req;
    logic            w_grant_core;
    logic [1:0]      w_sel_we;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic [7:0]      w_be;
    logic [DW-1:0]   w_wdata_rep;
    logic            w_misalign;
    logic            w_timeout;

    // Tie goes to whoever was not served last
    assign w_any_req    = c_req | d_req;
    assign w_grant_core = c_req & (~d_req | (r_last_owner == DEBUG));
    assign w_grant      = w_grant_core ? CORE : DEBUG;
    assign w_sel_we     = w_grant_core ? c_we    : d_we;
    assign w_sel_addr   = w_grant_core ? c_addr  : d_addr;
    assign w_sel_wdata  = w_grant_core ? c_wdata : d_wdata;
    assign w_timeout    = (r_cnt == CW'(TIMEOUT - 1)) & ~m_ready;

    mem_lane_gen u_lane_gen (
        .i_we       (w_sel_we),
        .i_addr     (w_sel_addr[2:0]),
        .i_wdata    (w_sel_wdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata_rep),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = w_misalign ? RESP : ACCESS;
            ACCESS:  if (m_ready || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner      <= NONE;
            r_last_owner <= DEBUG;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_c_rdata    <= '0;
            r_d_rdata    <= '0;
            m_en         <= 1'b0;
            m_we         <= 1'b0;
            m_be         <= '0;
            m_addr       <= '0;
            m_wdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_grant;
                        r_last_owner <= w_grant;
                        r_cnt        <= '0;
                        r_err        <= w_misalign;
                        if (w_misalign) begin
                            if (w_grant_core) r_c_rdata <= '0;
                            else              r_d_rdata <= '0;
                        end else begin
                            m_en    <= 1'b1;
                            m_we    <= (w_sel_we != MW_READ);
                            m_be    <= w_be;
                            m_addr  <= {w_sel_addr[AW-1:3], 3'b000};
                            m_wdata <= w_wdata_rep;
                        end
                    end
                end
                ACCESS: begin
                    if (m_ready) begin
                        m_en  <= 1'b0;
                        m_we  <= 1'b0;
                        r_err <= 1'b0;
                        if (!m_we) begin
                            if (r_owner == CORE) r_c_rdata <= m_rdata;
                            else                 r_d_rdata <= m_rdata;
                        end
                    end else if (w_timeout) begin
                        m_en  <= 1'b0;
                        m_we  <= 1'b0;
                        r_err <= 1'b1;
                        if (r_owner == CORE) r_c_rdata <= '0;
                        else                 r_d_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_owner <= NONE;
                    r_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign c_ack   = (r_state == RESP) && (r_owner == CORE);
    assign d_ack   = (r_state == RESP) && (r_owner == DEBUG);
    assign c_err   = c_ack & r_err;
    assign d_err   = d_ack & r_err;
    assign c_rdata = r_c_rdata;
    assign d_rdata = r_d_rdata;
    assign stall   = c_req & ~c_ack;
    assign owner   = r_owner;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the multicycle core and a debug/DMA requester.
- Sequences each access as issue, wait for memory ready, then respond.
- Translates the core's 2-bit memwrite size code into lane byte-enables and stalls the core while its access is outstanding.
- Sits between the core's memory interface (iord-selected address, memwrite, write data) and the memory macro.

Parameters:
AW, 32, byte-address width
DW, 64, memory data width (fixed 64; 8 byte lanes)
TIMEOUT, 15, max ACCESS cycles without m_ready before the access is aborted with error

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
c_req  in  1  core request, level; held with c_we/c_addr/c_wdata stable until c_ack
c_we  in  2  core size/write code: 00 read, 01 store word, 10 store byte, 11 store doubleword
c_addr  in  AW  core byte address
c_wdata  in  DW  core store data, right-aligned
c_rdata  out  DW  aligned 64-bit read data, valid when c_ack=1
c_ack  out  1  one-cycle completion pulse to core
c_err  out  1  valid with c_ack: misaligned or timed out
d_req, d_we, d_addr, d_wdata  in  1/2/AW/DW  debug requester, same rules as core
d_rdata, d_ack, d_err  out  DW/1/1  debug responses, same rules as core
m_en  out  1  memory access strobe, held high through ACCESS
m_we  out  1  write when 1
m_be  out  8  byte-lane enables
m_addr  out  AW  doubleword-aligned address {addr[AW-1:3],3'b000}
m_wdata  out  DW  lane-replicated store data
m_rdata  in  DW  memory read data, valid with m_ready
m_ready  in  1  memory completion, sampled only in ACCESS
stall  out  1  c_req & ~c_ack, combinational; gates core pcwrite/state advance
owner  out  2  debug view: 00 none, 01 core, 10 debug

Behaviour:
- Reset (async, reset_n=0): state IDLE; m_en=m_we=0; m_be=0; m_addr=0; m_wdata=0; all acks=0; all errs=0; rdata regs=0; timeout counter=0; last_owner=DEBUG so the core wins first tie. A reset mid-access aborts the access with no ack.
- States:
  - IDLE -> ACCESS on any req.
  - ACCESS -> RESP on m_ready or timeout.
  - IDLE -> RESP directly on misalign.
  - RESP -> IDLE unconditionally.
- Arbitration (IDLE only):
  - Single requester is granted.
  - When both request, grant the one that is not last_owner (round-robin).
  - On grant, latch owner, we, addr, wdata; update last_owner.
- Lane generation from latched addr a:
  - 00 read: be=FF.
  - 11: be=FF; requires a[2:0]=0.
  - 01: be=0F<<(4*a[2]); requires a[1:0]=0; wdata low word replicated to both halves.
  - 10: be=01<<a[2:0]; low byte replicated to all lanes.
  - m_we = (we!=00).
- Misaligned: no m_en. Go to RESP with err=1 and rdata=0.
- ACCESS: m_en=1 and all m_* outputs registered and stable for every cycle in the state.
  - Counter increments each ACCESS cycle.
  - m_ready=1 at an edge: capture m_rdata into owner's rdata; go to RESP; err=0.
  - If the counter reaches TIMEOUT with no m_ready: go to RESP with err=1 and rdata=0; m_en drops.
- RESP: m_en=0; owner's ack=1 for exactly this cycle; err is valid. Non-owner ack=0.
- Latency: req high in IDLE at edge N -> m_en high cycle N+1. m_ready high at edge N+1 -> ack in cycle N+2. Minimum is 3 cycles req to IDLE.
- Re-request: req is sampled only in IDLE. A req still high in the cycle after ack counts as a new request.
- A requester's inputs changing while it is not granted are ignored.
- m_ready outside ACCESS is ignored. m_rdata is never read for writes; rdata is unchanged on a write ack.
- Other owner's rdata, ack and err are unaffected by an access.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - owner enum {NONE, CORE, DEBUG}
  - size codes MW_READ=00, MW_WORD=01, MW_BYTE=10, MW_DWORD=11, matching the core's memwrite encoding
  - BE_ALL=8'hFF
- One combinational sub-module, mem_lane_gen: inputs we and addr[2:0]; outputs be, replicated wdata, misalign.

Test Plan:
- Core read at 0x40, m_ready one cycle after m_en, m_rdata=0x1122334455667788 -> m_be=FF, m_we=0, m_addr=0x40; c_ack pulse at the 3rd cycle; c_rdata=0x1122334455667788; stall falls with ack.
- Core store byte at 0x43, c_wdata=0xAB -> m_be=08, m_wdata=0xABABABABABABABAB, m_addr=0x40, m_we=1; c_ack; c_err=0.
- Core and debug both request from reset -> core granted first; debug granted next; both request again -> core then debug again (round-robin).
- Store word at 0x42 -> no m_en; c_ack at the next cycle with c_err=1; doubleword at 0x44 -> same.
- m_ready held low -> m_en high for exactly TIMEOUT cycles (15); then c_ack with c_err=1 and c_rdata=0.
- reset_n pulsed low mid-ACCESS -> m_en=0 and owner=00 immediately; no ack; next core req is serviced normally.
